delay_reader: RTL

Read side of the microphone delay buffer: stores mic samples into an internal circular RAM and delivers them, oldest first, on a valid/ready stream after a programmable startup delay of `offset` samples. It sits between the mic sample source (`en` strobe plus `mic_signal`) and a downstream consumer that may stall, such as a DAC feeder or a scope. Unlike a fixed `address - offset` tap, it tracks fill level, so a stalled consumer never reads stale or overwritten data.

---
 rtl/delay_reader.sv | 95 +++++++++
 1 files changed

// File: rtl/delay_reader.sv
// delay_reader: circular-RAM delay line that tracks fill level and streams samples oldest-first on valid/ready.
// Optional DELAY_READER_OVERRUN_EN: a write to a full buffer drops the oldest sample instead of being discarded.
module delay_reader #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] mic_signal,
    input  logic [A_WIDTH-1:0] offset,
    input  logic               resync,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [D_WIDTH-1:0] out_data,
    output logic [A_WIDTH-1:0] level,
    output logic               streaming,
    output logic               overrun
);
    localparam int DEPTH = 1 << A_WIDTH;
    localparam logic [A_WIDTH-1:0] LEVEL_MAX  = {A_WIDTH{1'b1}};
    localparam logic [A_WIDTH-1:0] OFFSET_MAX = {{(A_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t             state;
    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wr_ptr, rd_ptr, offset_q, offset_c;
    logic               full, issue, wr_en, drop;

    always_comb begin
        full     = (level == LEVEL_MAX);
        issue    = (state == STREAM) && (level != '0) && (!out_valid || out_ready);
        offset_c = (offset > OFFSET_MAX) ? OFFSET_MAX : offset;
`ifdef DELAY_READER_OVERRUN_EN
        wr_en = en && !resync;
        drop  = wr_en && full && !issue;
`else
        wr_en = en && !resync && !(full && !issue);
        drop  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= mic_signal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            offset_q  <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            streaming <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (resync) begin
                state     <= FILL;
                streaming <= 1'b0;
                offset_q  <= offset_c;
                rd_ptr    <= wr_ptr;
                level     <= '0;
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (en) begin
                        state    <= FILL;
                        offset_q <= offset_c;
                    end
                    FILL: if (level > offset_q) begin
                        state     <= STREAM;
                        streaming <= 1'b1;
                    end
                    default: ;
                endcase
                // a dropped sample advances the read side without changing level
                if (issue || drop) rd_ptr <= rd_ptr + 1'b1;
                if (wr_en && !issue && !drop) level <= level + 1'b1;
                else if (!wr_en && issue)     level <= level - 1'b1;
                if (issue) begin
                    out_valid <= 1'b1;
                    out_data  <= mem[rd_ptr];
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (drop) overrun <= 1'b1;
            end
        end
    end
endmodule
